// File: rtl/spi_slave_char_trx.sv
// spi_slave_char_trx: oversampling SPI slave that receives and transmits one 4..16-bit character
// per frame, with CPOL/CPHA/bit-order/length matching the SPI master's per-chip-select mode.
module spi_slave_char_trx #(
  parameter int CHAR_NBITS = 32
) (
  input  logic                  S_SYSCLK,
  input  logic                  S_RESET,
  input  logic                  S_ENABLE,
  input  logic                  S_CPOL,
  input  logic                  S_CPHA,
  input  logic                  S_REV,
  input  logic [3:0]            S_CHAR_LEN,
  input  logic                  S_SPI_CS,
  input  logic                  S_SPI_SCK,
  input  logic                  S_SPI_MOSI,
  output logic                  S_SPI_MISO,
  output logic                  S_CHAR_DONE,
  input  logic [CHAR_NBITS-1:0] S_WCHAR,
  output logic [CHAR_NBITS-1:0] S_RCHAR
);
  logic [1:0] sck_s, mosi_s, cs_s;
  logic [2:0] rdy;
  logic sck_r, mosi_r, cs_r, rise, fall, cs_fall, sel;
  logic lead, trail, smp, drv, active, last, tx_bit, w_bit, unused_hi;
  logic [3:0] top, cnt;
  logic [15:0] mask, tx, rx, tx_w, rx_n, tx_sh, w_sh;
  assign top = S_CHAR_LEN >= 4'd3 ? S_CHAR_LEN : 4'd7;
  assign mask = 16'hffff >> (4'd15 - top);
  assign tx_w = S_WCHAR[15:0] & mask;
  assign lead = S_CPOL ? fall : rise;
  assign trail = S_CPOL ? rise : fall;
  assign smp = S_CPHA ? trail : lead;
  assign drv = S_CPHA ? lead : trail;
  assign active = S_ENABLE & ~cs_r;
  assign last = cnt == top;
  assign rx_n = S_REV ? {rx[14:0], mosi_r} : rx | (16'(mosi_r) << cnt);
  assign tx_sh = S_REV ? tx << 1 : tx >> 1;
  assign w_sh = S_REV ? tx_w << 1 : tx_w >> 1;
  assign tx_bit = S_REV ? tx[top] : tx[0];
  assign w_bit = S_REV ? tx_w[top] : tx_w[0];
  assign unused_hi = ^S_WCHAR[CHAR_NBITS-1:16];
  // rdy masks the false CS fall seen while the reset values of the CS sync chain flush out
  always_ff @(posedge S_SYSCLK) begin
    if (S_RESET) begin
      sck_s <= '0;
      mosi_s <= '0;
      cs_s <= '1;
      sck_r <= 1'b0;
      mosi_r <= 1'b0;
      cs_r <= 1'b1;
      rise <= 1'b0;
      fall <= 1'b0;
      cs_fall <= 1'b0;
      rdy <= '0;
    end else begin
      sck_s <= {sck_s[0], S_SPI_SCK};
      mosi_s <= {mosi_s[0], S_SPI_MOSI};
      cs_s <= {cs_s[0], S_SPI_CS};
      sck_r <= sck_s[1];
      mosi_r <= mosi_s[1];
      cs_r <= cs_s[1];
      rise <= sck_s[1] & ~sck_r;
      fall <= ~sck_s[1] & sck_r;
      cs_fall <= rdy[2] & cs_r & ~cs_s[1];
      rdy <= {rdy[1:0], 1'b1};
    end
  end
  // the tx register always holds the bits not yet driven; a drive presents the head and shifts
  always_ff @(posedge S_SYSCLK) begin
    if (S_RESET || !active) begin
      sel <= 1'b0;
      cnt <= '0;
      tx <= '0;
      rx <= '0;
      S_SPI_MISO <= 1'b1;
      S_CHAR_DONE <= 1'b0;
      if (S_RESET) S_RCHAR <= '0;
    end else if (cs_fall) begin
      sel <= 1'b1;
      cnt <= '0;
      rx <= '0;
      S_CHAR_DONE <= 1'b0;
      tx <= S_CPHA ? tx_w : w_sh;
      if (!S_CPHA) S_SPI_MISO <= w_bit;
    end else begin
      S_CHAR_DONE <= sel & smp & last;
      if (sel & smp) begin
        cnt <= last ? '0 : cnt + 4'd1;
        rx <= last ? '0 : rx_n;
        if (last) S_RCHAR <= CHAR_NBITS'(rx_n);
      end
      if (sel & smp & last) tx <= tx_w;
      else if (sel & drv) begin
        tx <= tx_sh;
        S_SPI_MISO <= tx_bit;
      end
    end
  end
endmodule

// File: tb/tb_spi_slave_char_trx.sv
// tb_spi_slave_char_trx: directed SPI master driving the slave, with a scoreboard of expected
// characters, DONE latency, idle-MISO rules and hand-computed pins for each scenario.
module tb_spi_slave_char_trx;
  logic clk = 1'b0, rst, en, cpol, cpha, rev, cs, sck, mosi, miso, done;
  logic [3:0] len;
  logic [31:0] wchar, rchar, last_r = '0;
  int checks = 0, errs = 0, cyc = 0, ndone = 0, qage = 0, nd;
  logic [15:0] exp_q[$];
  int tq[$];
  logic [15:0] data[8];
  logic [15:0] cap;
  logic quiet = 1'b1, run = 1'b0, cs_p = 1'b1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_slave_char_trx #(.CHAR_NBITS(32)) dut (
    .S_SYSCLK(clk), .S_RESET(rst), .S_ENABLE(en), .S_CPOL(cpol), .S_CPHA(cpha), .S_REV(rev),
    .S_CHAR_LEN(len), .S_SPI_CS(cs), .S_SPI_SCK(sck), .S_SPI_MOSI(mosi), .S_SPI_MISO(miso),
    .S_CHAR_DONE(done), .S_WCHAR(wchar), .S_RCHAR(rchar)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // scoreboard: each DONE must match the next completed character, 4 cycles after its last sample edge
  always @(negedge clk) if (run) begin
    if (done) begin
      ndone++;
      if (exp_q.size() == 0) chk("spurious_done", 32'd1, 32'd0);
      else begin
        last_r = 32'(exp_q.pop_front());
        chk("done_latency", 32'(cyc - tq.pop_front()), 32'd4);
      end
    end
    chk("rchar", rchar, last_r);
    if (rst) last_r = '0;
    if (rst || !en || cs) begin
      if (!quiet) qage = 0;
      quiet = 1'b1;
    end else if (cs_p) quiet = 1'b0;
    if (quiet) qage++;
    if (quiet && qage >= 5) chk("miso_idle", 32'(miso), 32'd1);
    cs_p = cs;
  end

  // how: 0 = raise CS, 1 = drop enable, 2 = pulse reset, applied before bit stop_at
  task automatic frame(input logic pol, input logic pha, input logic r, input logic [3:0] l,
                       input logic [31:0] w, input int nch, input int stop_at, input int how);
    int n, b;
    logic [15:0] d, msk;
    n = (l >= 4'd3) ? int'(l) + 1 : 8;
    msk = 16'hffff >> (16 - n);
    cpol = pol; cpha = pha; rev = r; len = l; wchar = w; sck = pol;
    tick(6);
    cs = 1'b0;
    tick(8);
    b = 0;
    for (int c = 0; c < nch; c++) begin
      cap = '0;
      d = data[c];
      for (int k = 0; k < n; k++) begin
        if (b == stop_at) begin
          if (how == 0) cs = 1'b1;
          else if (how == 1) en = 1'b0;
          else begin rst = 1'b1; tick(2); rst = 1'b0; end
        end
        if (!pha) begin
          mosi = r ? d[n-1-k] : d[k];
          tick(6);
          cap = r ? {cap[14:0], miso} : cap | (16'(miso) << k);
          sck = ~pol;
          if (k == n - 1 && b < stop_at) begin exp_q.push_back(d & msk); tq.push_back(cyc); end
          tick(6);
          sck = pol;
        end else begin
          sck = ~pol;
          mosi = r ? d[n-1-k] : d[k];
          tick(6);
          cap = r ? {cap[14:0], miso} : cap | (16'(miso) << k);
          sck = pol;
          if (k == n - 1 && b < stop_at) begin exp_q.push_back(d & msk); tq.push_back(cyc); end
          tick(6);
        end
        b++;
      end
      if (stop_at >= (c + 1) * n) chk("miso_char", 32'(cap), 32'(w[15:0] & msk));
    end
    tick(6);
    cs = 1'b1;
    tick(8);
    en = 1'b1;
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; cs = 1'b1; sck = 1'b0; mosi = 1'b0;
    cpol = 1'b0; cpha = 1'b0; rev = 1'b1; len = 4'd7; wchar = '0;
    tick(3);
    chk("reset_miso", 32'(miso), 32'd1);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_rchar", rchar, 32'd0);
    rst = 1'b0;
    run = 1'b1;
    tick(4);
    // mode 0, MSB first, 8 bits
    data[0] = 16'h00A5; nd = ndone;
    frame(1'b0, 1'b0, 1'b1, 4'd7, 32'h1FAA5510, 1, 1000, 0);
    chk("t1_miso", 32'(cap), 32'h10);
    chk("t1_rchar", rchar, 32'h000000A5);
    chk("t1_ndone", 32'(ndone - nd), 32'd1);
    // mode 0, LSB first, LEN=0 means 8 bits
    data[0] = 16'h0001;
    frame(1'b0, 1'b0, 1'b0, 4'd0, 32'h1FAA5510, 1, 1000, 0);
    chk("t2_miso", 32'(cap), 32'h10);
    chk("t2_rchar", rchar, 32'h00000001);
    // mode 3, MSB first, 16 bits
    data[0] = 16'h1234;
    frame(1'b1, 1'b1, 1'b1, 4'd15, 32'h0000ABCD, 1, 1000, 0);
    chk("t3_miso", 32'(cap), 32'h0000ABCD);
    chk("t3_rchar", rchar, 32'h00001234);
    // seven back-to-back characters in one CS assertion
    for (int i = 0; i < 7; i++) data[i] = 16'(i + 1);
    nd = ndone;
    frame(1'b0, 1'b0, 1'b1, 4'd7, 32'h0000005A, 7, 1000, 0);
    chk("t4_ndone", 32'(ndone - nd), 32'd7);
    chk("t4_rchar", rchar, 32'h00000007);
    // CS abort after 4 bits, then a full frame
    data[0] = 16'h00FF; nd = ndone;
    frame(1'b0, 1'b0, 1'b1, 4'd7, 32'h1FAA5510, 1, 4, 0);
    chk("t5_ndone", 32'(ndone - nd), 32'd0);
    chk("t5_miso", 32'(miso), 32'd1);
    chk("t5_rchar", rchar, 32'h00000007);
    data[0] = 16'h003C;
    frame(1'b0, 1'b0, 1'b1, 4'd7, 32'h1FAA5510, 1, 1000, 0);
    chk("t5_next", rchar, 32'h0000003C);
    // enable dropped mid-frame
    data[0] = 16'h0081; nd = ndone;
    frame(1'b0, 1'b0, 1'b1, 4'd7, 32'h1FAA5510, 1, 4, 1);
    chk("t6_ndone", 32'(ndone - nd), 32'd0);
    chk("t6_miso", 32'(miso), 32'd1);
    chk("t6_rchar", rchar, 32'h0000003C);
    // reset pulsed mid-frame
    nd = ndone;
    frame(1'b0, 1'b0, 1'b1, 4'd7, 32'h1FAA5510, 1, 4, 2);
    chk("t7_ndone", 32'(ndone - nd), 32'd0);
    chk("t7_miso", 32'(miso), 32'd1);
    chk("t7_rchar", rchar, 32'd0);
    // recovery in mode 1, LSB first, 5 bits
    data[0] = 16'h0015;
    frame(1'b0, 1'b1, 1'b0, 4'd4, 32'hFFFFFF0B, 1, 1000, 0);
    chk("t8_miso", 32'(cap), 32'h0B);
    chk("t8_rchar", rchar, 32'h00000015);
    run = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end
endmodule
